// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / redirect controller for a six-stage in-order core.
// Per-stage hold vector (stall_o) with MEM > EX > ID priority, a one-cycle flush
// pulse carrying the redirect PC, and a MEMWAIT state that holds the pipe while a
// bus access is outstanding. A flush that arrives while the pipe is held on memory
// is remembered and issued as soon as the access completes.
// Optional feature: define PIPE_CTRL_WATCHDOG_EN to add an 8-bit MEMWAIT watchdog
// that abandons the wait after TIMEOUT_CYCLES and pulses timeout_o.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned PC_W           = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallreq_id_i,
   input  logic            stallreq_ex_i,
   input  logic            mem_req_i,
   input  logic            mem_ack_i,
   input  logic            flush_req_i,
   input  logic [PC_W-1:0] flush_pc_i,
   output logic [5:0]      stall_o,
   output logic            flush_o,
   output logic [PC_W-1:0] new_pc_o,
   output logic            timeout_o
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      FLUSH   = 2'd2
   } state_e;

   state_e          state_q;
   logic            pend_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] new_pc_q;
   logic            flush_q;
   logic            mem_hold_d;
   logic            wd_fire_d;

   // The watchdog counter is 8 bits wide, so the limit must fit in 1..255.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
      $error("pipe_ctrl: TIMEOUT_CYCLES must be in 1..255");
   end

`ifdef PIPE_CTRL_WATCHDOG_EN
   // Counter holds the number of MEMWAIT cycles already spent without an ack,
   // so the watchdog fires on the TIMEOUT_CYCLES-th MEMWAIT cycle.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wd_cnt_q;

   assign wd_fire_d = (state_q == MEMWAIT) && !mem_ack_i && (wd_cnt_q == WD_LAST);
   assign timeout_o = wd_fire_d;

   // Watchdog count: cleared on MEMWAIT entry, advanced on each un-acked wait cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_q <= 8'd0;
      end else if (state_q == RUN && mem_hold_d) begin
         wd_cnt_q <= 8'd0;
      end else if (state_q == MEMWAIT && mem_hold_d) begin
         wd_cnt_q <= wd_cnt_q + 8'd1;
      end
   end
`else
   assign wd_fire_d = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // MEM hold: raised by an un-acked access in RUN and kept through MEMWAIT
   // until the ack (or the watchdog) releases it; never asserted in FLUSH.
   always_comb begin
      mem_hold_d = 1'b0;
      case (state_q)
         RUN:     mem_hold_d = mem_req_i && !mem_ack_i;
         MEMWAIT: mem_hold_d = !mem_ack_i && !wd_fire_d;
         default: mem_hold_d = 1'b0;
      endcase
   end

   // Per-stage hold vector, highest-priority requester wins; FLUSH forces release.
   always_comb begin
      stall_o = 6'b000000;
      if (state_q != FLUSH) begin
         if (mem_hold_d) begin
            stall_o = 6'b011111;
         end else if (stallreq_ex_i) begin
            stall_o = 6'b001111;
         end else if (stallreq_id_i) begin
            stall_o = 6'b000111;
         end
      end
   end

   // Control FSM with registered flush pulse and redirect PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         pend_q   <= 1'b0;
         pc_q     <= '0;
         new_pc_q <= '0;
         flush_q  <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            MEMWAIT: begin
               if (flush_req_i) begin
                  pc_q <= flush_pc_i;
               end
               if (!mem_hold_d) begin
                  // Access finished (or abandoned): issue any remembered flush now.
                  if (pend_q || flush_req_i) begin
                     state_q  <= FLUSH;
                     flush_q  <= 1'b1;
                     new_pc_q <= flush_req_i ? flush_pc_i : pc_q;
                     pend_q   <= 1'b0;
                  end else begin
                     state_q <= RUN;
                  end
               end else if (flush_req_i) begin
                  pend_q <= 1'b1;
               end
            end
            FLUSH: begin
               // A request seen during the flush cycle buys one more flush cycle.
               if (flush_req_i) begin
                  pc_q     <= flush_pc_i;
                  new_pc_q <= flush_pc_i;
                  flush_q  <= 1'b1;
               end else begin
                  state_q <= RUN;
               end
            end
            default: begin
               state_q <= RUN;
               if (mem_hold_d) begin
                  state_q <= MEMWAIT;
                  if (flush_req_i) begin
                     pend_q <= 1'b1;
                     pc_q   <= flush_pc_i;
                  end
               end else if (flush_req_i) begin
                  state_q  <= FLUSH;
                  pc_q     <= flush_pc_i;
                  new_pc_q <= flush_pc_i;
                  flush_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign flush_o  = flush_q;
   assign new_pc_o = new_pc_q;

endmodule
